// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Data-side SRAM slave model answering EXE-stage load/store requests over a
//   req/addr_ok/data_ok handshake, one transaction outstanding, with a
//   configurable response latency. Word-organised storage, byte-strobe writes.
//
// Parameters
//   ADDR_WIDTH : word-index bits, depth = 2**ADDR_WIDTH 32-bit words
//   LATENCY    : cycles from the accept edge to data_ok (1..15)
//
// Ports
//   clk              : clock, rising-edge
//   reset            : asynchronous, active-high reset
//   data_sram_req    : request valid
//   data_sram_wr     : 1 = store, 0 = load
//   data_sram_size   : access size (informational; wstrb is authoritative)
//   data_sram_wstrb  : byte write enables for stores
//   data_sram_addr   : byte address (word index = addr[ADDR_WIDTH+1:2])
//   data_sram_wdata  : lane-aligned store data
//   data_sram_addr_ok: request accepted when req is also high
//   data_sram_data_ok: one-cycle response pulse
//   data_sram_rdata  : registered response word, held until the next response
//
// Optional feature
//   DATA_SRAM_RAND_DELAY_EN : 8-bit LFSR adds 0..3 extra wait cycles per
//   accept and masks addr_ok in IDLE whenever lfsr[2] is set.

module data_sram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_range_error
    $fatal(1, "data_sram_responder: LATENCY=%0d outside 1..15", LATENCY);
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, next_state;
  logic [4:0]  cnt, next_cnt;
  logic [31:0] rdata_buf;
  logic [31:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic        accept;
  logic [4:0]  extra;
  logic [4:0]  wait_cycles;
  logic [31:0] load_word;

  logic unused_inputs;
  assign unused_inputs = ^{data_sram_size, data_sram_addr};

  assign idx = data_sram_addr[ADDR_WIDTH+1:2];

`ifdef DATA_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;
  logic       idle_mask;

  // x^8+x^6+x^5+x^4+1, Fibonacci form shifting toward the MSB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= 8'h5A;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign extra     = {3'b000, lfsr[1:0]};
  assign idle_mask = lfsr[2];
`else
  logic idle_mask;
  assign extra     = '0;
  assign idle_mask = 1'b0;
`endif

  // WAIT cycles between the accept edge and the RESP cycle
  assign wait_cycles = 5'(LATENCY - 1) + extra;

  always_comb begin
    data_sram_addr_ok = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    data_sram_addr_ok = ~idle_mask;
        RESP:    data_sram_addr_ok = 1'b1;
        default: data_sram_addr_ok = 1'b0;
      endcase
    end
  end

  assign accept            = data_sram_req & data_sram_addr_ok;
  assign data_sram_data_ok = (state == RESP);
  assign load_word         = data_sram_wr ? '0 : mem[idx];

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          if (wait_cycles == '0) begin
            next_state = RESP;
          end else begin
            next_state = WAIT;
            next_cnt   = wait_cycles - 5'd1;
          end
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          next_state = RESP;
        end else begin
          next_cnt = cnt - 5'd1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      rdata_buf       <= '0;
      data_sram_rdata <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (accept) begin
        rdata_buf <= load_word;
      end
      // With a zero-wait accept the buffer is loaded on the same edge, so the
      // output register takes the freshly read word directly.
      if (next_state == RESP) begin
        data_sram_rdata <= accept ? load_word : rdata_buf;
      end
    end
  end

  // Storage is never reset; accept is already gated off while reset is high.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) begin
          mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  int          sel = 0;

  logic        ao0, dk0, ao1, dk1;
  logic [31:0] rd0, rd1;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mdl [2][1024];

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut_lat2 (
    .clk(clk), .reset(reset), .data_sram_req(req & (sel == 0)),
    .data_sram_wr(wr), .data_sram_size(size), .data_sram_wstrb(wstrb),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_addr_ok(ao0), .data_sram_data_ok(dk0), .data_sram_rdata(rd0)
  );

  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut_lat1 (
    .clk(clk), .reset(reset), .data_sram_req(req & (sel == 1)),
    .data_sram_wr(wr), .data_sram_size(size), .data_sram_wstrb(wstrb),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_addr_ok(ao1), .data_sram_data_ok(dk1), .data_sram_rdata(rd1)
  );

  assign addr_ok = (sel == 1) ? ao1 : ao0;
  assign data_ok = (sel == 1) ? dk1 : dk0;
  assign rdata   = (sel == 1) ? rd1 : rd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: word index is the byte address divided by 4, modulo depth.
  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % 1024);
  endfunction

  // Returns the value a response must carry and commits a store to the model.
  function automatic logic [31:0] model_access(input int s, input bit w,
      input logic [3:0] strb, input logic [31:0] a, input logic [31:0] d);
    int i = word_of(a);
    logic [31:0] old = mdl[s][i];
    if (!w) return old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) mdl[s][i][8*b +: 8] = d[8*b +: 8];
    return 32'h0;
  endfunction

  task automatic txn(input bit w, input logic [3:0] strb, input logic [31:0] a,
                     input logic [31:0] d, input string tag);
    int lat = (sel == 1) ? 1 : 2;
    int waited = 0;
    logic [31:0] exp;
    wr = w; wstrb = strb; addr = a; wdata = d; req = 1'b1;
    @(negedge clk);
    while (addr_ok !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_addr_ok"}, {31'b0, addr_ok}, 32'd1);
    exp = model_access(sel, w, strb, a, d);
    @(posedge clk); #1;
    req = 1'b0;
    wr = $urandom; addr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk({tag, "_data_ok"}, {31'b0, data_ok}, {31'b0, k == lat});
      if (k == lat) chk({tag, "_rdata"}, rdata, exp);
    end
    @(negedge clk);
    chk({tag, "_single_pulse"}, {31'b0, data_ok}, 32'd0);
    chk({tag, "_rdata_hold"}, rdata, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] exp_q [$];
    logic [31:0] a;
    int waited;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("rst_addr_ok_l2", {31'b0, ao0}, 32'd1);
      chk("rst_data_ok_l2", {31'b0, dk0}, 32'd0);
      chk("rst_rdata_l2", rd0, 32'h0);
      chk("rst_addr_ok_l1", {31'b0, ao1}, 32'd1);
      chk("rst_data_ok_l1", {31'b0, dk1}, 32'd0);
      chk("rst_rdata_l1", rd1, 32'h0);
    end
    @(posedge clk); #1;

    // Fill a pool of words on both instances so every later load is defined.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 16; i < 32; i++) txn(1'b1, 4'hF, 32'(i * 4), $urandom, "init");
    end

    sel = 0;
    txn(1'b1, 4'hF, 32'h100, 32'hDEADBEEF, "st_full");
    txn(1'b0, 4'h0, 32'h100, 32'h0, "ld_full");
    txn(1'b1, 4'b0010, 32'h101, 32'h0000AA00, "st_byte1");
    txn(1'b0, 4'h0, 32'h100, 32'h0, "ld_merged");
    chk("merged_word", mdl[0][64], 32'hDEADAAEF);
    txn(1'b1, 4'hF, 32'h1000, 32'h12345678, "st_alias");
    txn(1'b0, 4'h0, 32'h0000, 32'h0, "ld_alias");
    txn(1'b1, 4'h0, 32'h40, 32'hFFFFFFFF, "st_nostrobe");
    txn(1'b0, 4'h0, 32'h40, 32'h0, "ld_nostrobe");

    // LATENCY=1, four back-to-back loads with req held high.
    sel = 1;
    exp_q.delete();
    wr = 1'b0; req = 1'b1; addr = 32'h40;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        chk("b2b_addr_ok", {31'b0, addr_ok}, 32'd1);
        exp_q.push_back(model_access(1, 1'b0, 4'h0, addr, 32'h0));
      end
      chk("b2b_data_ok", {31'b0, data_ok}, {31'b0, i > 0});
      if (i > 0) chk("b2b_rdata", rdata, exp_q.pop_front());
      @(posedge clk); #1;
      if (i < 3) addr = 32'h40 + 32'((i + 1) * 4);
      else req = 1'b0;
    end
    @(negedge clk);
    chk("b2b_idle_data_ok", {31'b0, data_ok}, 32'd0);
    @(posedge clk); #1;

    // Store then a load of the same word accepted during the store's RESP.
    wr = 1'b1; wstrb = 4'b1100; addr = 32'h48; wdata = 32'hCAFE0000; req = 1'b1;
    @(negedge clk);
    chk("raw_st_addr_ok", {31'b0, addr_ok}, 32'd1);
    a = model_access(1, 1'b1, 4'b1100, 32'h48, 32'hCAFE0000);
    @(posedge clk); #1;
    wr = 1'b0; wstrb = 4'h0; addr = 32'h48;
    @(negedge clk);
    chk("raw_st_data_ok", {31'b0, data_ok}, 32'd1);
    chk("raw_st_rdata", rdata, a);
    chk("raw_ld_addr_ok", {31'b0, addr_ok}, 32'd1);
    a = model_access(1, 1'b0, 4'h0, 32'h48, 32'h0);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("raw_ld_data_ok", {31'b0, data_ok}, 32'd1);
    chk("raw_ld_rdata", rdata, a);
    @(posedge clk); #1;

    // Randomized traffic on both latencies.
    for (int t = 0; t < 80; t++) begin
      sel = int'($urandom_range(0, 1));
      a = 32'($urandom_range(16, 31) * 4) + 32'($urandom_range(0, 3))
          + (32'($urandom_range(0, 7)) << 12);
      txn(1'($urandom), 4'($urandom), a, $urandom, "rand");
    end

    // Reset during WAIT of a load on the LATENCY=2 instance.
    sel = 0;
    txn(1'b0, 4'h0, 32'h100, 32'h0, "pre_reset_ld");
    wr = 1'b0; addr = 32'h100; req = 1'b1;
    waited = 0;
    @(negedge clk);
    while (addr_ok !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("rstw_addr_ok", {31'b0, addr_ok}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rstw_data_ok", {31'b0, data_ok}, 32'd0);
    chk("rstw_addr_ok_low", {31'b0, addr_ok}, 32'd0);
    chk("rstw_rdata_clr", rdata, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("rstw_hold_data_ok", {31'b0, data_ok}, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rstw_post_data_ok", {31'b0, data_ok}, 32'd0);
      chk("rstw_post_addr_ok", {31'b0, addr_ok}, 32'd1);
    end
    @(posedge clk); #1;
    txn(1'b0, 4'h0, 32'h100, 32'h0, "post_reset_ld");
    chk("post_reset_word", mdl[0][64], 32'hDEADAAEF);
    txn(1'b0, 4'h0, 32'h0, 32'h0, "post_reset_alias");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
